// File: rtl/ula_sequenciador.sv
// ula_sequenciador: multi-cycle controller that sequences an external 4-bit ALU against a 4-entry register bank.
module ula_sequenciador #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       cmd_op,
  input  logic [1:0]       cmd_rd,
  input  logic [1:0]       cmd_ra,
  input  logic [1:0]       cmd_rb,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic [1:0]       cmd_cnt,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_res,
  input  logic [1:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_val
);
  typedef enum logic [1:0] {IDLE, LOAD, EXEC, WB} state_t;
  state_t           state;
  logic [3:0]       op;
  logic [1:0]       rd, ra, rb, cnt, iter;
  logic [WIDTH-1:0] imm, acc;
  logic             ill;
  logic [WIDTH-1:0] regs [NREGS];
  assign dbg_val = regs[dbg_sel];
  // alu_a doubles as the feedback operand, so it carries each iteration's result into the next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      zero    <= 1'b0;
      result  <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      iter    <= '0;
      op      <= '0;
      rd      <= '0;
      ra      <= '0;
      rb      <= '0;
      cnt     <= '0;
      imm     <= '0;
      acc     <= '0;
      ill     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            op    <= cmd_op;
            rd    <= cmd_rd;
            ra    <= cmd_ra;
            rb    <= cmd_rb;
            imm   <= cmd_imm;
            cnt   <= cmd_cnt;
            ill   <= cmd_op > 4'd8;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (!op[3]) begin
            alu_a   <= regs[ra];
            alu_b   <= regs[rb];
            alu_sel <= op[2:0];
            iter    <= cnt;
            state   <= EXEC;
          end else begin
            acc   <= imm;
            state <= WB;
          end
        end
        EXEC: begin
          alu_a <= alu_res;
          if (iter == 2'd0) begin
            acc   <= alu_res;
            state <= WB;
          end else iter <= iter - 2'd1;
        end
        WB: begin
          if (!ill) begin
            regs[rd] <= acc;
            result   <= acc;
            zero     <= acc == '0;
          end else begin
            result <= '0;
            zero   <= 1'b0;
            err    <= 1'b1;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ula_sequenciador.sv
// tb_ula_sequenciador: directed and random commands checked against a register-bank reference model.
`timescale 1ns/1ps
module tb_ula_sequenciador;
  logic       clk = 0, rst_n = 0, start = 0;
  logic [3:0] cmd_op = 0, cmd_imm = 0;
  logic [1:0] cmd_rd = 0, cmd_ra = 0, cmd_rb = 0, cmd_cnt = 0, dbg_sel = 0;
  logic       busy, done, err, zero;
  logic [3:0] result, alu_a, alu_b, alu_res, dbg_val;
  logic [2:0] alu_sel;
  int         n = 0, fails = 0;
  logic [3:0] mr [4];

  ula_sequenciador dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_op(cmd_op), .cmd_rd(cmd_rd),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm), .cmd_cnt(cmd_cnt),
    .busy(busy), .done(done), .err(err), .result(result), .zero(zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res),
    .dbg_sel(dbg_sel), .dbg_val(dbg_val)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_f(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    case (s)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~a;
      3'd3: return ~(a & b);
      3'd4: return a + b;
      3'd5: return a - b;
      3'd6: return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  assign alu_res = alu_f(alu_sel, alu_a, alu_b);

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_regs();
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1 chk($sformatf("reg%0d", i), dbg_val, mr[i]);
    end
  endtask

  task automatic run(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                     input logic [1:0] rb, input logic [3:0] imm, input logic [1:0] cnt, input bit inj);
    int         k, lat;
    logic [3:0] a, b, exp;
    bit         il;
    cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm; cmd_cnt = cnt;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    lat = (op < 8) ? int'(cnt) + 3 : 2;
    k = 0;
    do begin
      @(posedge clk);
      #1 k++;
      if (k == 1) begin
        chk("busy_after_accept", busy, 1);
        chk("done_cleared", done, 0);
      end
      if (inj) begin
        start = (k == 2);
        if (k == 2) begin cmd_op = 8; cmd_rd = 0; cmd_imm = 9; end
      end
    end while (!done && k < 20);
    start = 0;
    chk("latency", 8'(k), 8'(lat));
    il = op > 8;
    if (op < 8) begin
      a = mr[ra]; b = mr[rb];
      for (int i = 0; i <= int'(cnt); i++) a = alu_f(op[2:0], a, b);
      exp = a;
      mr[rd] = a;
    end else if (op == 8) begin
      exp = imm;
      mr[rd] = imm;
    end else exp = 0;
    chk("result", result, exp);
    chk("zero", zero, !il && exp == 0);
    chk("err", err, il);
    chk("busy_at_done", busy, 0);
    chk_regs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) mr[i] = 0;
    #12;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    chk("rst_result", result, 0); chk("rst_zero", zero, 0);
    chk("rst_alu_a", alu_a, 0); chk("rst_alu_b", alu_b, 0); chk("rst_alu_sel", alu_sel, 0);
    chk_regs();
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    run(8, 1, 0, 0, 5, 0, 0);
    run(8, 2, 0, 0, 3, 0, 0);
    run(4, 0, 1, 2, 0, 0, 0);
    chk("add_result_8", result, 8);
    run(5, 3, 2, 1, 0, 0, 0);
    chk("sub_wrap_14", result, 14);
    run(5, 3, 1, 1, 0, 0, 0);
    chk("sub_zero", zero, 1);
    run(6, 2, 1, 0, 0, 3, 0);
    chk("shl_iter_result", result, 0);
    run(4, 1, 1, 1, 0, 3, 1);
    run(12, 2, 1, 1, 7, 0, 0);
    run(3, 0, 0, 0, 0, 1, 0);
    for (int t = 0; t < 40; t++)
      run(($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7)),
          2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom), 2'($urandom), 0);
    run(8, 1, 0, 0, 7, 0, 0);
    cmd_op = 4; cmd_rd = 3; cmd_ra = 1; cmd_rb = 1; cmd_cnt = 2;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    @(posedge clk);
    #1 chk("exec_alu_a_live", alu_a, 7);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0); chk("mid_rst_err", err, 0);
    chk("mid_rst_result", result, 0); chk("mid_rst_zero", zero, 0);
    chk("mid_rst_alu_a", alu_a, 0); chk("mid_rst_alu_b", alu_b, 0); chk("mid_rst_alu_sel", alu_sel, 0);
    for (int i = 0; i < 4; i++) mr[i] = 0;
    chk_regs();
    @(negedge clk) rst_n = 1;
    repeat (6) begin
      @(posedge clk);
      #1 chk("no_done_after_rst", done, 0);
    end
    chk_regs();
    run(8, 3, 0, 0, 6, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule

// File: doc/ula_sequenciador.md
Name: ula_sequenciador

Overview:
- Multi-cycle controller that sequences the shared 4-bit ALU (8 ops, 3-bit selector) against a small internal register bank.
- Accepts one command per start/busy/done handshake, reads operands from the bank, drives the ALU, optionally re-applies the op with the result fed back, and writes back the result with a zero flag.
- Sits between the top-level command source and the combinational ALU instance; the ALU itself is external.

Parameters:
- WIDTH, 4, data width of registers and ALU ports; fixed at 4 to match the ALU.
- NREGS, 4, register bank depth; addresses are 2 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- start  in  1  command strobe; sampled only in IDLE
- cmd_op  in  4  0-7 = ALU op (selector value), 8 = LOADI, 9-15 illegal
- cmd_rd  in  2  destination register
- cmd_ra  in  2  source A register
- cmd_rb  in  2  source B register
- cmd_imm  in  4  immediate for LOADI
- cmd_cnt  in  2  extra iterations; op applied cmd_cnt+1 times
- busy  out  1  high from accept until done
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done on illegal op
- result  out  4  last written value; held until next done
- zero  out  1  result == 0; updated with done
- alu_a  out  4  ALU operand A
- alu_b  out  4  ALU operand B
- alu_sel  out  3  ALU selector
- alu_res  in  4  ALU result (combinational from alu_a/alu_b/alu_sel)
- dbg_sel  in  2  register bank debug read address
- dbg_val  out  4  regs[dbg_sel], combinational

Behaviour:
- Reset (async, rst_n=0): state=IDLE; regs[0..3]=0; busy, done, err, zero=0; result=0; alu_a, alu_b=0; alu_sel=000; internal iteration counter=0.
- FSM states: IDLE, LOAD, EXEC, WB.
- IDLE: if start=1 at a clock edge, latch all cmd_* fields, set busy=1, and go to LOAD. done/err are cleared on this edge if they were set.
- LOAD:
  - ALU op 0-7: opA<=regs[ra], opB<=regs[rb], alu_sel<=op[2:0], iter<=cnt; go to EXEC.
  - LOADI: acc<=imm; go to WB.
  - Illegal op: go to WB with the error marked.
- EXEC:
  - alu_a=opA, alu_b=opB; at each edge opA<=alu_res.
  - If iter==0, go to WB; else decrement iter and stay in EXEC. EXEC lasts cnt+1 cycles.
  - Feedback always replaces A; B is constant for the whole command.
- WB:
  - Legal op: regs[rd]<=final value, result<=final value, zero<=(final value==0).
  - Illegal op: no register write, result<=0, zero<=0, err<=1.
  - Always done<=1, busy<=0; go to IDLE.
- done and err are high for exactly one cycle, the first IDLE cycle after WB.
- Latency, with start sampled at edge E:
  - ALU op: done high during [E+3+cnt, E+4+cnt).
  - LOADI and illegal op: done high during [E+2, E+3).
- start while busy=1 is ignored; command inputs are don't-care while busy.
- start in the done cycle is accepted, giving back-to-back operation.
- Arithmetic wraps modulo 16; no carry or overflow is reported.
- Source and destination may alias (ra=rb=rd). Operands are captured in LOAD, so the WB write never affects the current command.
- alu_a, alu_b, alu_sel hold their last values outside EXEC.
- Reset asserted mid-command aborts immediately to the reset values; no partial write-back occurs.

Test Plan:
- Bench connects an ALU model: 0 AND, 1 OR, 2 NOT A, 3 NAND, 4 ADD, 5 SUB, 6 SHL by 1 with zero fill, 7 SHR by 1 with zero fill.
- LOADI r1=5, then LOADI r2=3, then op 4 rd=0 ra=1 rb=2 cnt=0 -> done at E+3, result=8, zero=0, dbg_sel=0 reads 8; each LOADI done at E+2.
- op 5 rd=3 ra=2 rb=1 (3-5) -> result=14 (wrap); then op 5 rd=3 ra=1 rb=1 -> result=0, zero=1.
- r1=5, op 6 rd=2 ra=1 cnt=3 -> iterations 10, 4, 8, 0; done at E+6, result=0, zero=1, r2=0, r1 still 5.
- Busy/illegal: pulse start with LOADI r0=9 while a cnt=3 command is running -> ignored, r0 unchanged. Then op 12 -> err=1 and done=1 at E+2, result=0, no register changes. Then start in the done cycle -> accepted, busy=1 on the next cycle.
- Reset: drop rst_n during EXEC of cnt=2 op 4 rd=3 -> all outputs and regs return to 0 without waiting for a clock edge; after release, no done pulse and r3=0.
